cordic_atan_sched: RTL and testbench
====================================

Name: cordic_atan_sched

Overview:
- Round-robin scheduler that shares one fully pipelined 11-stage CORDIC arctangent datapath among N requesters.
- Accepts at most one (x,y) operand pair per cycle and drives it into the pipeline.
- Carries a requester tag alongside each operation in a matched-latency shadow pipe.
- Returns each 12-bit angle with the ID of the requester that issued it. Sits between DSP front-end channels and the shared atan pipeline.

Parameters:
- N, 4, number of requesters (2..8).
- IDW, 2, requester ID width; must satisfy 2^IDW >= N.
- LAT, 11, register latency of the attached atan pipeline, from operand registered on tx_cx/tx_cy to angle valid on rx_cz.
- CNTW, 5, in-flight counter width; must satisfy 2^CNTW > LAT+2.

Ports:
- rx_clk  in  1  clock, rising edge.
- rx_rst  in  1  reset, asynchronous, active-high.
- rx_en  in  1  1 = grants allowed; 0 = no new grants, in-flight operations drain.
- rx_req_vld  in  N  per-requester operand valid.
- tx_req_rdy  out  N  per-requester ready; one-hot or zero.
- rx_req_x  in  32*N  packed signed x operands; requester i occupies [32i+31:32i].
- rx_req_y  in  32*N  packed signed y operands, same packing as x.
- tx_cx  out  32  x operand to the pipeline, registered.
- tx_cy  out  32  y operand to the pipeline, registered.
- rx_cz  in  12  angle from the pipeline output.
- tx_res_vld  out  1  result valid, single-cycle pulse per operation.
- tx_res_id  out  IDW  requester ID of the result.
- tx_res_z  out  12  angle in signed units of 1/1024 rad (pi/4 = 804).
- tx_inflight  out  CNTW  number of issued operations not yet returned.
- tx_idle  out  1  1 when tx_inflight==0 and no rx_req_vld bit is set.

Behaviour:
- Reset (asynchronous assert, synchronous release): tx_req_rdy=0, tx_cx=0, tx_cy=0, tx_res_vld=0, tx_res_id=0, tx_res_z=0, tx_inflight=0, round-robin pointer=N-1, tag pipe fully invalid. tx_idle is 1 once reset deasserts with no requests pending.
- Arbitration (combinational): when rx_en=1, tx_req_rdy is one-hot on the first asserted rx_req_vld, searching from pointer+1 upward with wrap. With rx_en=0 or no requests, tx_req_rdy=0.
- Transfer: occurs when rx_req_vld[i] & tx_req_rdy[i]. Requesters must hold vld and operands stable until the transfer.
- On a transfer edge:
  - pointer <= i;
  - tx_cx/tx_cy <= operands of requester i;
  - tag pipe stage 0 <= {1, i}.
- No transfer in a cycle: tx_cx/tx_cy are driven to 0 and tag stage 0 is invalid. The pipeline cannot stall, so bubbles are explicit.
- Tag pipe: LAT+1 stages, shifts every cycle unconditionally. Stage 0 is aligned with tx_cx; stage LAT is aligned with rx_cz.
- Result register, each cycle:
  - tx_res_vld <= tag[LAT].valid;
  - tx_res_id <= tag[LAT].id;
  - tx_res_z <= rx_cz when valid, else hold.
- Latency: handshake in cycle c gives tx_cx in c+1, rx_cz in c+1+LAT, tx_res_vld in c+2+LAT (cycle 13 for default LAT and c=0).
- Throughput: 1 operation per cycle sustained. Results never backpressure; consumers must accept every pulse.
- Fairness: with all N requesters continuously valid, grants rotate 0,1,..,N-1,0,... Each requester waits at most N-1 cycles.
- tx_inflight: +1 on transfer, -1 on tx_res_vld, unchanged when both occur in the same cycle. It never exceeds LAT+2.
- rx_en falling while operations are in flight: issued operations still complete and return. Pointer is unchanged.
- Reset asserted mid-operation: all tags are discarded immediately, no tx_res_vld pulses follow, and the counter clears. The pipeline is reset by the same rx_rst, so no stale data aliases into new tags.
- The block performs no quadrant correction. Operands with x<0 give an out-of-range angle; that correction is the requester's responsibility.
- Out-of-range requester index cannot be granted (only bits 0..N-1 are examined).

Test Plan:
- Reset mid-stream: assert rx_rst at an arbitrary point during traffic, then stream 20 operations from requester 2 -> no tx_res_vld before the first post-reset result; every later result has id 2 and results are in order.
- Single operation: req0 issues x=1000, y=1000 in cycle 0 -> tx_res_vld exactly in cycle 13 with id 0, z=804 +/-2; tx_inflight rises to 1 and returns to 0.
- Zero angle and sign: req1 x=4096, y=0 -> z=0 +/-1; req1 x=4096, y=-4096 -> z=-804 +/-2.
- All-valid fairness: all four requesters valid for 16 cycles -> grant order 0,1,2,3 repeated 4 times; 16 results arrive in issue order with matching ids; peak tx_inflight=13.
- Gating: hold rx_en=0 with requests pending -> tx_req_rdy=0 and in-flight work drains to tx_inflight=0, then tx_idle=0 while requests remain. Raise rx_en -> grant resumes from pointer+1.
- Boundary: a transfer and a result in the same cycle -> tx_inflight unchanged.

Source files
------------

// File: rtl/cordic_atan_sched_if.sv
// ---------------------------------------------------------------------------
// cordic_atan_sched_if
//   Groups the signals of the shared-atan scheduler: the requester side
//   (per-requester valid/ready plus packed x/y operands), the operand
//   interface to the atan pipeline (tx_cx/tx_cy out, rx_cz back), and the
//   tagged result stream with the status outputs.
//
//   master : the scheduler's view (drives tx_*, samples rx_*)
//   slave  : the environment's view (requesters, pipeline, result consumer)
// ---------------------------------------------------------------------------
interface cordic_atan_sched_if #(
  parameter int N    = 4,
  parameter int IDW  = 2,
  parameter int CNTW = 5
);
  logic              rx_en;
  logic [N-1:0]      rx_req_vld;
  logic [N-1:0]      tx_req_rdy;
  logic [32*N-1:0]   rx_req_x;
  logic [32*N-1:0]   rx_req_y;
  logic [31:0]       tx_cx;
  logic [31:0]       tx_cy;
  logic [11:0]       rx_cz;
  logic              tx_res_vld;
  logic [IDW-1:0]    tx_res_id;
  logic [11:0]       tx_res_z;
  logic [CNTW-1:0]   tx_inflight;
  logic              tx_idle;

  modport master (
    input  rx_en, rx_req_vld, rx_req_x, rx_req_y, rx_cz,
    output tx_req_rdy, tx_cx, tx_cy, tx_res_vld, tx_res_id, tx_res_z,
           tx_inflight, tx_idle
  );

  modport slave (
    output rx_en, rx_req_vld, rx_req_x, rx_req_y, rx_cz,
    input  tx_req_rdy, tx_cx, tx_cy, tx_res_vld, tx_res_id, tx_res_z,
           tx_inflight, tx_idle
  );
endinterface

// File: rtl/cordic_atan_sched.sv
// ---------------------------------------------------------------------------
// cordic_atan_sched
//   Round-robin scheduler sharing one fully pipelined atan datapath among N
//   requesters. At most one operand pair is granted per cycle and registered
//   onto tx_cx/tx_cy; idle cycles drive zero operands (explicit bubbles, the
//   pipeline cannot stall). A shadow tag pipe of LAT+1 stages carries
//   {valid, requester id} alongside each operation so the angle returning on
//   rx_cz can be re-associated with its requester.
//
//   Ports:
//     rx_clk      clock, rising edge
//     rx_rst      asynchronous active-high reset (also resets the pipeline)
//     bus.rx_en   grant enable; 0 stops new grants, in-flight work drains
//     bus.rx_req_vld / bus.tx_req_rdy   per-requester handshake
//     bus.rx_req_x / bus.rx_req_y       packed operands, requester i at [32i+:32]
//     bus.tx_cx / bus.tx_cy             registered operands to the pipeline
//     bus.rx_cz                         angle from the pipeline, LAT cycles later
//     bus.tx_res_vld/_id/_z             one-cycle result pulse with requester id
//     bus.tx_inflight                   issued-but-not-returned operation count
//     bus.tx_idle                       nothing in flight and nothing requested
// ---------------------------------------------------------------------------
module cordic_atan_sched #(
  parameter int N    = 4,
  parameter int IDW  = 2,
  parameter int LAT  = 11,
  parameter int CNTW = 5
) (
  input  logic                  rx_clk,
  input  logic                  rx_rst,
  cordic_atan_sched_if.master   bus
);

  typedef struct packed {
    logic           vld;
    logic [IDW-1:0] id;
  } tag_t;

  // Round-robin pointer holds the most recently granted requester.
  logic [IDW-1:0]  ptr_q,      ptr_d;
  logic [31:0]     cx_q,       cx_d;
  logic [31:0]     cy_q,       cy_d;
  tag_t            tag_q [0:LAT];
  tag_t            tag_d [0:LAT];
  logic            res_vld_q,  res_vld_d;
  logic [IDW-1:0]  res_id_q,   res_id_d;
  logic [11:0]     res_z_q,    res_z_d;
  logic [CNTW-1:0] inflight_q, inflight_d;

  logic [N-1:0]    gnt;
  logic            gnt_any;
  logic [IDW-1:0]  gnt_id;

  // -------------------------------------------------------------------------
  // Arbitration: first asserted valid searching from ptr+1 upward with wrap.
  // -------------------------------------------------------------------------
  always_comb begin : arb
    int idx;
    // NOTE: every variable written here gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    idx     = 0;
    gnt     = '0;
    gnt_any = 1'b0;
    gnt_id  = '0;
    if (bus.rx_en) begin
      for (int k = 1; k <= N; k++) begin
        idx = int'(ptr_q) + k;
        if (idx >= N) idx = idx - N;
        if (!gnt_any && bus.rx_req_vld[idx]) begin
          gnt_any     = 1'b1;
          gnt_id      = IDW'(idx);
          gnt[idx]    = 1'b1;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Next-state: operand issue, tag shift, result capture, in-flight count.
  // -------------------------------------------------------------------------
  always_comb begin : nxt
    ptr_d    = ptr_q;
    cx_d     = '0;
    cy_d     = '0;
    tag_d[0] = '0;
    if (gnt_any) begin
      ptr_d    = gnt_id;
      cx_d     = bus.rx_req_x[int'(gnt_id)*32 +: 32];
      cy_d     = bus.rx_req_y[int'(gnt_id)*32 +: 32];
      tag_d[0] = '{vld: 1'b1, id: gnt_id};
    end

    // Tag pipe shifts every cycle: stage 0 lines up with tx_cx, stage LAT
    // lines up with rx_cz.
    for (int k = 1; k <= LAT; k++) tag_d[k] = tag_q[k-1];

    res_vld_d = tag_q[LAT].vld;
    res_id_d  = tag_q[LAT].id;
    res_z_d   = tag_q[LAT].vld ? bus.rx_cz : res_z_q;

    // A transfer and a returning result in the same cycle cancel out.
    inflight_d = inflight_q;
    unique case ({gnt_any, res_vld_q})
      2'b10:   inflight_d = inflight_q + CNTW'(1);
      2'b01:   inflight_d = inflight_q - CNTW'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers.
  // -------------------------------------------------------------------------
  always_ff @(posedge rx_clk or posedge rx_rst) begin
    if (rx_rst) begin
      ptr_q      <= IDW'(N-1);
      cx_q       <= '0;
      cy_q       <= '0;
      // NOTE: the tag pipe is reset stage by stage, unlike a data RAM: a
      // surviving valid bit would emit a phantom result after reset.
      for (int k = 0; k <= LAT; k++) tag_q[k] <= '0;
      res_vld_q  <= 1'b0;
      res_id_q   <= '0;
      res_z_q    <= '0;
      inflight_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values;
      // the tag shift depends on it.
      ptr_q      <= ptr_d;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      for (int k = 0; k <= LAT; k++) tag_q[k] <= tag_d[k];
      res_vld_q  <= res_vld_d;
      res_id_q   <= res_id_d;
      res_z_q    <= res_z_d;
      inflight_q <= inflight_d;
    end
  end

  assign bus.tx_req_rdy  = gnt;
  assign bus.tx_cx       = cx_q;
  assign bus.tx_cy       = cy_q;
  assign bus.tx_res_vld  = res_vld_q;
  assign bus.tx_res_id   = res_id_q;
  assign bus.tx_res_z    = res_z_q;
  assign bus.tx_inflight = inflight_q;
  assign bus.tx_idle     = (inflight_q == '0) && !(|bus.rx_req_vld);

endmodule

// File: tb/tb_cordic_atan_sched.sv
// ---------------------------------------------------------------------------
// tb_cordic_atan_sched
//   Directed bench for cordic_atan_sched. A behavioural LAT-stage atan
//   pipeline (reset by the same rst) closes the loop from tx_cx/tx_cy back
//   to rx_cz. Inputs are driven 1 time unit after the rising edge; outputs
//   are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_cordic_atan_sched;
  localparam int N    = 4;
  localparam int IDW  = 2;
  localparam int LAT  = 11;
  localparam int CNTW = 5;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cordic_atan_sched_if #(.N(N), .IDW(IDW), .CNTW(CNTW)) bus ();

  cordic_atan_sched #(.N(N), .IDW(IDW), .LAT(LAT), .CNTW(CNTW)) dut (
    .rx_clk (clk),
    .rx_rst (rst),
    .bus    (bus)
  );

  // Reference atan: round(atan2(y,x) * 1024), 12-bit two's complement.
  function automatic logic [11:0] atan_model(input logic [31:0] x, input logic [31:0] y);
    real r;
    int  z;
    r = $atan2(real'($signed(y)), real'($signed(x))) * 1024.0;
    z = (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
    return 12'(z);
  endfunction

  // Behavioural atan pipeline: LAT registers from tx_cx/tx_cy to rx_cz.
  logic [11:0] pipe [0:LAT-1];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < LAT; k++) pipe[k] <= '0;
    end else begin
      pipe[0] <= atan_model(bus.tx_cx, bus.tx_cy);
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
  end
  assign bus.rx_cz = pipe[LAT-1];

  // Monitor: log results and grants on the falling edge.
  logic [IDW-1:0] res_id_q  [$];
  int             res_z_q   [$];
  int             res_cyc_q [$];
  logic [N-1:0]   gnt_q     [$];

  always @(negedge clk) begin
    if (bus.tx_res_vld) begin
      res_id_q.push_back(bus.tx_res_id);
      res_z_q.push_back(int'($signed(bus.tx_res_z)));
      res_cyc_q.push_back(cyc);
    end
    if (|bus.tx_req_rdy) gnt_q.push_back(bus.tx_req_rdy);
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    else             n_pass++;
  endtask

  task automatic clear_logs();
    res_id_q.delete();
    res_z_q.delete();
    res_cyc_q.delete();
    gnt_q.delete();
  endtask

  // Raise vld for one requester and wait (bounded) for its grant. Returns at
  // posedge+1 after the transfer with vld still set; hs is the grant cycle.
  task automatic issue_hold(input int id, input logic [31:0] xv,
                            input logic [31:0] yv, output int hs);
    int t;
    t  = 0;
    hs = -1;
    bus.rx_req_vld[id]        = 1'b1;
    bus.rx_req_x[32*id +: 32] = xv;
    bus.rx_req_y[32*id +: 32] = yv;
    while (hs < 0 && t < 20) begin
      @(negedge clk);
      if (bus.tx_req_rdy[id]) hs = cyc;
      @(posedge clk); #1;
      t++;
    end
    check($sformatf("grant_seen_req%0d", id), 32'(hs >= 0), 1);
  endtask

  task automatic issue(input int id, input logic [31:0] xv,
                       input logic [31:0] yv, output int hs);
    issue_hold(id, xv, yv, hs);
    bus.rx_req_vld[id] = 1'b0;
  endtask

  task automatic wait_results(input string tag, input int n, input int budget);
    int t;
    t = 0;
    while (res_id_q.size() < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    #1;
    check(tag, res_id_q.size(), n);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Operands for the all-valid tests and their hand-computed angles.
  int tab_x [N] = '{1000, 4096,  4096,    0};
  int tab_y [N] = '{1000,    0, -4096, 4096};
  int tab_z [N] = '{ 804,    0,  -804, 1608};

  initial begin
    int hs0, hs1, peak, first_hs;
    int exp_z [$];

    rst            = 1'b1;
    bus.rx_en      = 1'b0;
    bus.rx_req_vld = '0;
    bus.rx_req_x   = '0;
    bus.rx_req_y   = '0;

    // ---------------- reset state ----------------
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rdy",      32'(bus.tx_req_rdy),  0);
    check("rst_cx",       bus.tx_cx,            0);
    check("rst_cy",       bus.tx_cy,            0);
    check("rst_res_vld",  32'(bus.tx_res_vld),  0);
    check("rst_res_id",   32'(bus.tx_res_id),   0);
    check("rst_res_z",    32'(bus.tx_res_z),    0);
    check("rst_inflight", 32'(bus.tx_inflight), 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("idle_after_rst", 32'(bus.tx_idle), 1);

    // ---------------- single operation ----------------
    @(posedge clk); #1;
    bus.rx_en = 1'b1;
    clear_logs();
    issue(0, 1000, 1000, hs0);
    @(negedge clk);
    check("single_cx",       bus.tx_cx, 1000);
    check("single_cy",       bus.tx_cy, 1000);
    check("single_inflight", 32'(bus.tx_inflight), 1);
    wait_results("single_count", 1, 40);
    if (res_id_q.size() >= 1) begin
      check("single_latency", res_cyc_q[0] - hs0, 13);
      check("single_id",      32'(res_id_q[0]), 0);
      check("single_z",       res_z_q[0], 804);
    end
    @(negedge clk);
    check("single_pulse_end", 32'(bus.tx_res_vld), 0);
    check("single_z_hold",    32'($signed(bus.tx_res_z)), 804);
    check("single_drained",   32'(bus.tx_inflight), 0);
    check("single_idle",      32'(bus.tx_idle), 1);

    // ---------------- zero angle and negative sign ----------------
    @(posedge clk); #1;
    clear_logs();
    issue(1, 4096, 0, hs0);
    issue(1, 4096, -4096, hs1);
    check("sign_back_to_back", hs1 - hs0, 1);
    wait_results("sign_count", 2, 40);
    if (res_id_q.size() >= 2) begin
      check("zero_id",  32'(res_id_q[0]), 1);
      check("zero_z",   res_z_q[0], 0);
      check("neg_id",   32'(res_id_q[1]), 1);
      check("neg_z",    res_z_q[1], -804);
    end

    // ---------------- all-valid fairness ----------------
    @(posedge clk); #1;
    pulse_reset();
    clear_logs();
    peak = 0;
    for (int i = 0; i < N; i++) begin
      bus.rx_req_x[32*i +: 32] = tab_x[i];
      bus.rx_req_y[32*i +: 32] = tab_y[i];
    end
    bus.rx_en      = 1'b1;
    bus.rx_req_vld = '1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      check($sformatf("fair_inflight%0d", k), 32'(bus.tx_inflight), (k < 13) ? k : 13);
      if (int'(bus.tx_inflight) > peak) peak = int'(bus.tx_inflight);
      @(posedge clk); #1;
    end
    bus.rx_req_vld = '0;
    @(negedge clk);
    // Cycle 16: result arrives, no transfer, counter still at its peak.
    check("fair_inflight16", 32'(bus.tx_inflight), 13);
    if (int'(bus.tx_inflight) > peak) peak = int'(bus.tx_inflight);
    check("fair_peak", peak, 13);
    check("fair_gnt_count", gnt_q.size(), 16);
    for (int i = 0; i < 16 && i < gnt_q.size(); i++)
      check($sformatf("fair_gnt%0d", i), 32'(gnt_q[i]), 1 << (i % N));
    wait_results("fair_count", 16, 60);
    for (int i = 0; i < 16 && i < res_id_q.size(); i++) begin
      check($sformatf("fair_id%0d", i), 32'(res_id_q[i]), i % N);
      check($sformatf("fair_z%0d", i),  res_z_q[i], tab_z[i % N]);
    end
    repeat (3) @(negedge clk);
    check("fair_drained", 32'(bus.tx_inflight), 0);

    // ---------------- rx_en gating ----------------
    @(posedge clk); #1;
    clear_logs();
    bus.rx_req_vld = '1;
    repeat (3) @(posedge clk);
    #1 bus.rx_en = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k < 4) check($sformatf("gate_rdy%0d", k), 32'(bus.tx_req_rdy), 0);
    end
    check("gate_drained", 32'(bus.tx_inflight), 0);
    check("gate_not_idle", 32'(bus.tx_idle), 0);
    check("gate_count", res_id_q.size(), 3);
    for (int i = 0; i < 3 && i < res_id_q.size(); i++)
      check($sformatf("gate_id%0d", i), 32'(res_id_q[i]), i);
    @(posedge clk); #1 bus.rx_en = 1'b1;
    @(negedge clk);
    check("gate_resume_rdy", 32'(bus.tx_req_rdy), 4'b1000);
    @(posedge clk); #1 bus.rx_req_vld = '0;
    wait_results("gate_resume_count", 4, 40);
    if (res_id_q.size() >= 4) begin
      check("gate_resume_id", 32'(res_id_q[3]), 3);
      check("gate_resume_z",  res_z_q[3], 1608);
    end

    // ---------------- reset mid-stream ----------------
    @(posedge clk); #1;
    bus.rx_req_vld = '1;
    repeat (6) @(posedge clk);
    #3;
    rst            = 1'b1;
    bus.rx_req_vld = '0;
    @(negedge clk);
    check("midrst_res_vld",  32'(bus.tx_res_vld),  0);
    check("midrst_inflight", 32'(bus.tx_inflight), 0);
    check("midrst_cx",       bus.tx_cx,            0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    clear_logs();
    first_hs = -1;
    for (int k = 0; k < 20; k++) begin
      issue_hold(2, 4096, k * 100, hs0);
      if (k == 0) first_hs = hs0;
      exp_z.push_back(int'($signed(atan_model(32'd4096, 32'(k * 100)))));
    end
    bus.rx_req_vld[2] = 1'b0;
    wait_results("stream_count", 20, 60);
    if (res_id_q.size() >= 1)
      check("stream_first_latency", res_cyc_q[0] - first_hs, 13);
    for (int i = 0; i < 20 && i < res_id_q.size(); i++) begin
      check($sformatf("stream_id%0d", i), 32'(res_id_q[i]), 2);
      check($sformatf("stream_z%0d", i),  res_z_q[i], exp_z[i]);
    end
    repeat (20) @(negedge clk);
    check("stream_no_extra", res_id_q.size(), 20);
    check("stream_drained",  32'(bus.tx_inflight), 0);
    check("stream_idle",     32'(bus.tx_idle), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
